game_state_controller: RTL and testbench
========================================

# game_state_controller

Sequences the match flow for the display pipeline: start menu, optional pre-round countdown, play, and win/lose/draw end screens. It consumes IR remote commands, attack strobes, health values and the new-frame pulse. It drives the registered mode flags that select the start screen, the live game layers and the end screens in the display mux. It also gates saber/attack rendering through `game_active_out`.

## Interface
- `START_CODE_A`, 32'h20DF_5BA4, IR code that starts a match
- `START_CODE_B`, 32'h20DF_5AA5, alternate start code
- `RESTART_CODE`, 32'h20DF_10EF, IR code that returns from an end screen to START
- `COUNT_FRAMES`, 60, frames per countdown digit (min 1)
- `END_HOLD_FRAMES`, 120, frames an end screen is held before restart is accepted
- `clk_in` input 1: system/pixel clock
- `rst_in` input 1: synchronous, active-high reset
- `nf_in` input 1: one-cycle new-frame pulse
- `ir_valid_in` input 1: one-cycle strobe, `ir_in` holds a fresh decoded command
- `ir_in` input 32: decoded IR command
- `attack_valid_in` input 1: an attack was registered this cycle
- `player_health_in` input 3: player health, 0 = dead
- `opponent_health_in` input 3: opponent health, 0 = dead
- `state_out` output 3: START=0, COUNTDOWN=1, PLAY=2, WIN=3, LOSE=4, DRAW=5
- `display_start_out` output 1: high in START
- `game_active_out` output 1: high in PLAY
- `end_win_out` / `end_lose_out` / `end_draw_out` output 1 each: high in WIN / LOSE / DRAW
- `countdown_out` output 2: digit shown during COUNTDOWN (3,2,1), else 0
- `round_frames_out` output 16: frames elapsed in current PLAY, saturating at 16'hFFFF

## Operation
- All outputs are registered and decoded from the next-state value, so flags track `state_out` exactly.
- Reset values: `state_out`=START, `display_start_out`=1, all other outputs 0, internal `ever_attack`=0, frame counters 0.
- START: `ir_valid_in` with `ir_in`==`START_CODE_A` or `START_CODE_B` moves to COUNTDOWN. It moves to PLAY when the countdown is compiled out. On entry, `countdown_out`=3, the digit frame counter=0, `round_frames_out`=0 and `ever_attack`=0.
- COUNTDOWN:
  - Each `nf_in` increments the digit frame counter.
  - When the counter reaches `COUNT_FRAMES`-1 on an `nf_in`, it clears and the digit decrements.
  - When that event occurs at digit 1, the state moves to PLAY.
  - IR commands are ignored.
- PLAY:
  - `attack_valid_in` sets `ever_attack`.
  - Each `nf_in` increments `round_frames_out`, which saturates.
  - End checks apply only when `ever_attack`=1, or when `attack_valid_in` is high in the same cycle.
  - player==0 and opponent!=0 moves to LOSE.
  - opponent==0 and player!=0 moves to WIN.
  - Both 0 in the same cycle moves to DRAW.
  - Health is ignored before the first attack, so power-up zero health never ends a match.
- WIN/LOSE/DRAW:
  - The hold counter counts `nf_in` pulses and saturates at `END_HOLD_FRAMES`.
  - After saturation, `ir_valid_in` with `RESTART_CODE` moves to START.
  - A start code is also accepted after saturation and moves to START.
  - Before saturation, all IR commands are ignored.
- IR input is acted on only when `ir_valid_in`=1. A held `ir_in` value alone never triggers anything.
- Unused state encodes 6 and 7 recover to START on the next cycle.

## Timing
- Event-to-output latency is one clock: the triggering input is sampled at edge N and outputs change after edge N.
- An `nf_in` and a state-entry in the same cycle: entry initialisation wins and that frame is not counted.
- `attack_valid_in` together with an end condition in the same PLAY cycle: the end condition is taken.
- `rst_in` mid-operation (any state, any counter value) returns to the reset values on the next edge. No residual flags are left.
- `COUNT_FRAMES`=1: each digit lasts exactly one frame, so COUNTDOWN takes 3 `nf_in` pulses.

## Configuration
- `GAME_COUNTDOWN_EN` defined: COUNTDOWN state and `countdown_out` behave as above.
- Undefined:
  - A start code goes START→PLAY directly.
  - `countdown_out` is tied to 0.
  - State 1 is unreachable and recovers to START.
  - The digit counter logic is removed.

## Test plan
- Reset, then hold `ir_in`=32'h20DF_5BA4 with no `ir_valid_in` for 10 cycles -> stays START with `display_start_out`=1. Pulse `ir_valid_in` -> `state_out`=1 and `countdown_out`=3 one cycle later.
- `COUNT_FRAMES`=2 with countdown enabled: 6 `nf_in` pulses -> `countdown_out` goes 3,3→2,2→1,1→0. `state_out`=2 and `game_active_out`=1 after the 6th pulse.
- PLAY with player=0, opponent=3 and no attack for 100 cycles -> stays PLAY. One `attack_valid_in` -> `end_lose_out`=1 next cycle.
- PLAY after an attack: player and opponent drop to 0 in the same cycle -> `state_out`=5 and `end_draw_out`=1. Opponent alone at 0 in another run -> WIN.
- WIN with `END_HOLD_FRAMES`=4: `RESTART_CODE` after 3 frames is ignored. After the 4th `nf_in`, `RESTART_CODE` -> START. On re-entry `round_frames_out`=0 and `ever_attack`=0.
- Assert `rst_in` for one cycle during COUNTDOWN digit 2 -> next cycle `state_out`=0, `display_start_out`=1, `countdown_out`=0.

Source files
------------

// File: rtl/game_state_controller.sv
// Match-flow sequencer: START -> (COUNTDOWN) -> PLAY -> WIN/LOSE/DRAW -> START.
// Define GAME_COUNTDOWN_EN to include the pre-round 3-2-1 countdown.
module game_state_controller #(
  parameter logic [31:0] START_CODE_A    = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B    = 32'h20DF_5AA5,
  parameter logic [31:0] RESTART_CODE    = 32'h20DF_10EF,
  parameter int          COUNT_FRAMES    = 60,
  parameter int          END_HOLD_FRAMES = 120
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        nf_in,
  input  logic        ir_valid_in,
  input  logic [31:0] ir_in,
  input  logic        attack_valid_in,
  input  logic [2:0]  player_health_in,
  input  logic [2:0]  opponent_health_in,
  output logic [2:0]  state_out,
  output logic        display_start_out,
  output logic        game_active_out,
  output logic        end_win_out,
  output logic        end_lose_out,
  output logic        end_draw_out,
  output logic [1:0]  countdown_out,
  output logic [15:0] round_frames_out
);

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_WIN       = 3'd3,
    ST_LOSE      = 3'd4,
    ST_DRAW      = 3'd5
  } state_t;

  localparam int             HW       = $clog2(END_HOLD_FRAMES + 2);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(END_HOLD_FRAMES);

  state_t          state;
  state_t          state_nxt;
  logic            ever_attack;
  logic            ever_attack_nxt;
  logic [15:0]     round_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_nxt;
  logic            start_hit;
  logic            restart_hit;
  logic            end_armed;

`ifdef GAME_COUNTDOWN_EN
  localparam int             CW      = $clog2(COUNT_FRAMES + 1);
  localparam logic [CW-1:0]  CF_LAST = CW'(COUNT_FRAMES - 1);

  logic [CW-1:0]   digit_cnt;
  logic [CW-1:0]   digit_cnt_nxt;
  logic [1:0]      countdown_nxt;
`else
  // COUNT_FRAMES has no role when the countdown is compiled out.
  logic unused_count_frames;
  assign unused_count_frames = (COUNT_FRAMES == 0);
  assign countdown_out       = 2'd0;
`endif

  assign start_hit   = ir_valid_in && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));
  assign restart_hit = ir_valid_in && ((ir_in == RESTART_CODE) || (ir_in == START_CODE_A) ||
                                       (ir_in == START_CODE_B));
  assign end_armed   = ever_attack || attack_valid_in;

  always_comb begin
    state_nxt       = state;
    ever_attack_nxt = ever_attack;
    round_nxt       = round_frames_out;
    hold_nxt        = hold_cnt;
`ifdef GAME_COUNTDOWN_EN
    digit_cnt_nxt   = digit_cnt;
    countdown_nxt   = countdown_out;
`endif
    case (state)
      ST_START: begin
        if (start_hit) begin
`ifdef GAME_COUNTDOWN_EN
          state_nxt     = ST_COUNTDOWN;
          countdown_nxt = 2'd3;
          digit_cnt_nxt = '0;
`else
          state_nxt     = ST_PLAY;
`endif
          round_nxt       = 16'd0;
          ever_attack_nxt = 1'b0;
        end
      end
`ifdef GAME_COUNTDOWN_EN
      ST_COUNTDOWN: begin
        if (nf_in) begin
          if (digit_cnt == CF_LAST) begin
            digit_cnt_nxt = '0;
            countdown_nxt = countdown_out - 2'd1;
            if (countdown_out == 2'd1) state_nxt = ST_PLAY;
          end else begin
            digit_cnt_nxt = digit_cnt + CW'(1);
          end
        end
      end
`endif
      ST_PLAY: begin
        if (attack_valid_in) ever_attack_nxt = 1'b1;
        if (nf_in && (round_frames_out != 16'hFFFF)) round_nxt = round_frames_out + 16'd1;
        // Health only matters once an attack has been seen, so zeroed power-up values are harmless.
        if (end_armed) begin
          if ((player_health_in == 3'd0) && (opponent_health_in == 3'd0)) begin
            state_nxt = ST_DRAW;
            hold_nxt  = '0;
          end else if (player_health_in == 3'd0) begin
            state_nxt = ST_LOSE;
            hold_nxt  = '0;
          end else if (opponent_health_in == 3'd0) begin
            state_nxt = ST_WIN;
            hold_nxt  = '0;
          end
        end
      end
      ST_WIN, ST_LOSE, ST_DRAW: begin
        if (hold_cnt == HOLD_MAX) begin
          if (restart_hit) begin
            state_nxt       = ST_START;
            round_nxt       = 16'd0;
            ever_attack_nxt = 1'b0;
            hold_nxt        = '0;
          end
        end else if (nf_in) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_nxt       = ST_START;
        round_nxt       = 16'd0;
        ever_attack_nxt = 1'b0;
        hold_nxt        = '0;
      end
    endcase
`ifdef GAME_COUNTDOWN_EN
    if (state_nxt != ST_COUNTDOWN) countdown_nxt = 2'd0;
`endif
  end

  // Flags are decoded from the next state so they always agree with state_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= ST_START;
      state_out         <= 3'd0;
      display_start_out <= 1'b1;
      game_active_out   <= 1'b0;
      end_win_out       <= 1'b0;
      end_lose_out      <= 1'b0;
      end_draw_out      <= 1'b0;
      round_frames_out  <= 16'd0;
      ever_attack       <= 1'b0;
      hold_cnt          <= '0;
`ifdef GAME_COUNTDOWN_EN
      digit_cnt         <= '0;
      countdown_out     <= 2'd0;
`endif
    end else begin
      state             <= state_nxt;
      state_out         <= state_nxt;
      display_start_out <= (state_nxt == ST_START);
      game_active_out   <= (state_nxt == ST_PLAY);
      end_win_out       <= (state_nxt == ST_WIN);
      end_lose_out      <= (state_nxt == ST_LOSE);
      end_draw_out      <= (state_nxt == ST_DRAW);
      round_frames_out  <= round_nxt;
      ever_attack       <= ever_attack_nxt;
      hold_cnt          <= hold_nxt;
`ifdef GAME_COUNTDOWN_EN
      digit_cnt         <= digit_cnt_nxt;
      countdown_out     <= countdown_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus random traffic against a frame-count model.
module tb_game_state_controller;

  localparam int CF = 2;
  localparam int EH = 4;
  localparam logic [31:0] CODE_A = 32'h20DF_5BA4;
  localparam logic [31:0] CODE_B = 32'h20DF_5AA5;
  localparam logic [31:0] CODE_R = 32'h20DF_10EF;
`ifdef GAME_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        nf;
  logic        irv;
  logic [31:0] ir;
  logic        att;
  logic [2:0]  ph;
  logic [2:0]  oh;
  logic [2:0]  state_out;
  logic        display_start_out, game_active_out, end_win_out, end_lose_out, end_draw_out;
  logic [1:0]  countdown_out;
  logic [15:0] round_frames_out;

  int n_cmp  = 0;
  int n_fail = 0;

  game_state_controller #(
    .COUNT_FRAMES(CF),
    .END_HOLD_FRAMES(EH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .nf_in(nf), .ir_valid_in(irv), .ir_in(ir),
    .attack_valid_in(att), .player_health_in(ph), .opponent_health_in(oh),
    .state_out(state_out), .display_start_out(display_start_out),
    .game_active_out(game_active_out), .end_win_out(end_win_out),
    .end_lose_out(end_lose_out), .end_draw_out(end_draw_out),
    .countdown_out(countdown_out), .round_frames_out(round_frames_out)
  );

  always #5 clk = ~clk;

  logic [25:0] dut_vec;
  assign dut_vec = {state_out, display_start_out, game_active_out, end_win_out, end_lose_out,
                    end_draw_out, countdown_out, round_frames_out};

  // Model: mode number plus plain counts (countdown frames seen, play frames, end-screen frames).
  int m_state = 0;
  int m_cd_frames = 0;
  int m_round = 0;
  int m_ever = 0;
  int m_hold = 0;

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_cd_frames = 0; m_round = 0; m_ever = 0; m_hold = 0;
    end else begin
      case (m_state)
        0: if (irv && (ir == CODE_A || ir == CODE_B)) begin
             m_state = CD_EN ? 1 : 2;
             m_cd_frames = 0; m_round = 0; m_ever = 0;
           end
        1: if (nf) begin
             m_cd_frames++;
             if (m_cd_frames == 3 * CF) m_state = 2;
           end
        2: begin
             if (nf && m_round < 65535) m_round++;
             if (att) m_ever = 1;
             if (m_ever == 1) begin
               if (ph == 0 && oh == 0) begin m_state = 5; m_hold = 0; end
               else if (ph == 0)       begin m_state = 4; m_hold = 0; end
               else if (oh == 0)       begin m_state = 3; m_hold = 0; end
             end
           end
        default: begin
             if (m_hold == EH && irv && (ir == CODE_R || ir == CODE_A || ir == CODE_B)) begin
               m_state = 0; m_round = 0; m_ever = 0; m_hold = 0;
             end else if (nf && m_hold < EH) begin
               m_hold++;
             end
           end
      endcase
    end
  endtask

  function automatic logic [25:0] exp_vec();
    int cd;
    cd = (m_state == 1) ? 3 - m_cd_frames / CF : 0;
    return {3'(m_state), m_state == 0, m_state == 2, m_state == 3, m_state == 4, m_state == 5,
            2'(cd), 16'(m_round)};
  endfunction

  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_play();
    rst = 1'b1; drive_cycle(); rst = 1'b0;
    ir = CODE_B; irv = 1'b1; drive_cycle(); irv = 1'b0;
    for (int i = 0; i < 40 && m_state != 2; i++) begin
      nf = 1'b1; drive_cycle(); nf = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_cycle(); rst = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
    end
    ir = CODE_A; irv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle();
      n_cmp++;
      if (dut_vec !== exp_vec() || display_start_out !== 1'b1) begin
        n_fail++; $display("FAIL held_ir_no_valid: got %h want %h", dut_vec, exp_vec());
      end
    end
    irv = 1'b1; drive_cycle(); irv = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_pulse: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_countdown();
    for (int p = 0; p < 6; p++) begin
      nf = 1'b1; drive_cycle(); nf = 1'b0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL countdown_pulse%0d: got %h want %h", p, dut_vec, exp_vec());
      end
      drive_cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL countdown_gap%0d: got %h want %h", p, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (state_out !== 3'd2 || game_active_out !== 1'b1) begin
      n_fail++; $display("FAIL countdown_to_play: got state %0d active %b want 2 1",
                         state_out, game_active_out);
    end
  endtask

  task automatic test_lose();
    ph = 3'd0; oh = 3'd3;
    for (int i = 0; i < 100; i++) begin
      nf = ($urandom_range(0, 3) == 0);
      drive_cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL no_attack_hold: got %h want %h", dut_vec, exp_vec());
      end
    end
    nf = 1'b0;
    att = 1'b1; drive_cycle(); att = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || end_lose_out !== 1'b1) begin
      n_fail++; $display("FAIL attack_to_lose: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 3; i++) begin
      nf = 1'b1; drive_cycle(); nf = 1'b0;
    end
    ir = CODE_R; irv = 1'b1; drive_cycle(); irv = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || state_out !== 3'd4) begin
      n_fail++; $display("FAIL early_restart: got %h want %h", dut_vec, exp_vec());
    end
    nf = 1'b1; drive_cycle(); nf = 1'b0;
    irv = 1'b1; drive_cycle(); irv = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || state_out !== 3'd0 || round_frames_out !== 16'd0) begin
      n_fail++; $display("FAIL restart_to_start: got %h want %h", dut_vec, exp_vec());
    end
    ph = 3'd0; oh = 3'd3;
    ir = CODE_A; irv = 1'b1; drive_cycle(); irv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nf = 1'b1; drive_cycle(); nf = 1'b0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL ever_attack_cleared: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_draw();
    ph = 3'd3; oh = 3'd3; goto_play();
    att = 1'b1; drive_cycle(); att = 1'b0;
    ph = 3'd0; oh = 3'd0; drive_cycle();
    n_cmp++;
    if (dut_vec !== exp_vec() || state_out !== 3'd5 || end_draw_out !== 1'b1) begin
      n_fail++; $display("FAIL draw: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_win();
    ph = 3'd3; oh = 3'd3; goto_play();
    oh = 3'd0; drive_cycle();
    n_cmp++;
    if (dut_vec !== exp_vec() || state_out !== 3'd2) begin
      n_fail++; $display("FAIL win_before_attack: got %h want %h", dut_vec, exp_vec());
    end
    att = 1'b1; drive_cycle(); att = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || end_win_out !== 1'b1) begin
      n_fail++; $display("FAIL attack_with_win: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    ph = 3'd3; oh = 3'd3;
    rst = 1'b1; drive_cycle(); rst = 1'b0;
    ir = CODE_A; irv = 1'b1; drive_cycle(); irv = 1'b0;
    for (int i = 0; i < CF; i++) begin
      nf = 1'b1; drive_cycle(); nf = 1'b0;
    end
    rst = 1'b1; drive_cycle(); rst = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || countdown_out !== 2'd0 || display_start_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_run: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      nf  = ($urandom_range(0, 2) == 0);
      att = ($urandom_range(0, 24) == 0);
      irv = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 3);
      ir = (r == 0) ? CODE_A : (r == 1) ? CODE_B : (r == 2) ? CODE_R : $urandom;
      ph = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      oh = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      drive_cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    rst = 1'b0; nf = 1'b0; att = 1'b0; irv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; nf = 1'b0; irv = 1'b0; ir = 32'd0; att = 1'b0; ph = 3'd3; oh = 3'd3;
    @(posedge clk); #1;
    test_reset();
    test_countdown();
    test_lose();
    test_restart();
    test_draw();
    test_win();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
